// File: rtl/nr_pkg.sv
// Shared definitions for the nanoRisk fetch-stage program counter:
// default widths/vectors and the sequencing state encoding.
package nr_pkg;

  localparam int          PC_W_DEFAULT      = 8;
  localparam logic [7:0]  RESET_VEC_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/nr_pc_incrementer.sv
// Combinational pc + STEP, truncated to PC_W, with the carry out of the top bit
// so the caller can tell a wrap from an ordinary increment.
module nr_pc_incrementer #(
  parameter int          PC_W = 8,
  parameter int unsigned STEP = 1
) (
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] sum,
  output logic            carry
);

  assign {carry, sum} = {1'b0, pc} + (PC_W+1)'(STEP);

endmodule

// File: rtl/nr_program_counter.sv
// Fetch-stage PC with redirect/flush, stall and halt/resume sequencing.
// Optional macro NR_PC_TRAP_EN: sequential overflow halts the core and raises trap.
module nr_program_counter
  import nr_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEFAULT),
  parameter int unsigned     STEP      = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flux,
  input  logic [PC_W-1:0] target,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc,
  output logic            flush,
`ifdef NR_PC_TRAP_EN
  output logic            trap,
`endif
  output logic            halted
);

  pc_state_e state;

`ifdef NR_PC_TRAP_EN
  logic carry;
`else
  // Without the trap feature a wrap is silent, so the carry has no consumer.
  logic carry_unused;
`endif

  nr_pc_incrementer #(
    .PC_W (PC_W),
    .STEP (STEP)
  ) u_incrementer (
    .pc    (pc),
    .sum   (pc_inc),
`ifdef NR_PC_TRAP_EN
    .carry (carry)
`else
    .carry (carry_unused)
`endif
  );

  always_ff @(posedge clock) begin
    // NOTE: all state is updated with non-blocking assignments so every branch
    // reads the pre-edge values of pc/state regardless of statement order.
    if (reset) begin
      pc     <= RESET_VEC;
      state  <= ST_RUN;
      flush  <= 1'b0;
      halted <= 1'b0;
`ifdef NR_PC_TRAP_EN
      trap   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          if (stall) begin
            // Upstream keeps flux/target stable, so they are acted on once stall drops.
          end else if (halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (flux) begin
            pc    <= target;
            state <= ST_FLUSH;
            flush <= 1'b1;
`ifdef NR_PC_TRAP_EN
          end else if (carry) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            trap   <= 1'b1;
`endif
          end else begin
            pc <= pc_inc;
          end
        end

        ST_FLUSH: begin
          // flux/halt here belong to the squashed instruction and are dropped.
          state <= ST_RUN;
          flush <= 1'b0;
`ifdef NR_PC_TRAP_EN
          // An overflowing step is deferred; the following RUN cycle raises the trap.
          if (!stall && !carry) pc <= pc_inc;
`else
          if (!stall) pc <= pc_inc;
`endif
        end

        ST_HALT: begin
          if (resume) begin
            pc     <= pc_inc;
            state  <= ST_RUN;
            halted <= 1'b0;
`ifdef NR_PC_TRAP_EN
            trap   <= 1'b0;
`endif
          end
        end

        default: begin
          state  <= ST_RUN;
          flush  <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
